// File: rtl/ss_scan_driver.sv
// ss_scan_driver: multiplexed seven-segment display driver.
// Time-slices one segment bus across N_DIGITS common-anode digits, decodes
// each nibble to a hex glyph and applies blank/blink/dp/leading-zero rules.
// Inputs are captured once per frame so a refresh never mixes two values.
module ss_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int PRESCALE     = 1000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic [N_DIGITS-1:0]   blink_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    // Internal decode is active-low; INV flips every output for active-high boards.
    localparam logic INV = (ACTIVE_LOW == 0);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  slot_end;
    logic                  frame_wrap;
    logic                  primed;
    logic                  capture;

    logic [4*N_DIGITS-1:0] sh_digits;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_blank;
    logic [N_DIGITS-1:0]   sh_blink;
    logic                  sh_lz;

    logic [BLK_W-1:0]      blk_cnt;
    logic                  blink_on;

    logic [N_DIGITS-1:0]   lz_mask;
    logic                  run_zero;

    logic [3:0]            cur_val;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_blink;
    logic                  cur_lz;
    logic                  cur_dark;
    logic                  in_dead;

    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [N_DIGITS-1:0]   an_nxt;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);
    assign capture    = frame_wrap || !primed;

    // Hex glyph table, active-low, bit 6 = g down to bit 0 = a.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // Slot-cycle counter and digit index; the index advances when a slot ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow capture at each frame wrap, plus once on the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed    <= 1'b0;
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_lz     <= 1'b0;
        end else begin
            primed <= 1'b1;
            if (capture) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_blink  <= blink_in;
                sh_lz     <= lz_en;
            end
        end
    end

    // Blink phase flips after every BLINK_FRAMES completed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt  <= '0;
            blink_on <= 1'b1;
        end else if (frame_wrap) begin
            if (blk_cnt == BLK_LAST) begin
                blk_cnt  <= '0;
                blink_on <= ~blink_on;
            end else begin
                blk_cnt <= blk_cnt + BLK_W'(1);
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while every digit seen is 0; digit 0 is never masked.
    always_comb begin
        lz_mask  = '0;
        run_zero = sh_lz;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            run_zero   = run_zero && (sh_digits[4*i +: 4] == 4'd0);
            lz_mask[i] = run_zero;
        end
    end

    // Select the shadowed attributes of the digit whose slot is running.
    always_comb begin
        cur_val   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_val   = sh_digits[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
                cur_blink = sh_blink[i];
                cur_lz    = lz_mask[i];
            end
        end
    end

    // Next output values (active-low); dark digits keep their anode slot so brightness stays even.
    always_comb begin
        cur_dark = cur_blank || (cur_blink && !blink_on) || cur_lz;
        in_dead  = (int'({1'b0, cnt}) < DEAD);
        seg_nxt  = cur_dark ? 7'b1111111 : glyph(cur_val);
        dp_nxt   = ~(cur_dp && !cur_dark);
        an_nxt   = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_nxt[i] = ~(!in_dead && (idx == IDX_W'(i)));
        end
    end

    // Output registers; reset forces everything to the inactive level immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= {7{~INV}};
            dp          <= ~INV;
            an          <= {N_DIGITS{~INV}};
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_nxt ^ {7{INV}};
            dp          <= dp_nxt ^ INV;
            an          <= an_nxt ^ {N_DIGITS{INV}};
            frame_start <= capture;
        end
    end

endmodule

// File: tb/tb_ss_scan_driver.sv
// tb_ss_scan_driver: table-driven bench for ss_scan_driver with four digits,
// four clocks per slot, one dead cycle and a two-frame blink half-period.
module tb_ss_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp_bits;
        logic [3:0]  blank_bits;
        logic [3:0]  blink_bits;
        logic        lz;
        logic [27:0] seg_exp;
        logic [3:0]  dp_exp;
    } vec_t;

    vec_t vecs[$];

    logic [6:0] glyphs [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] DARK = 7'b1111111;

    ss_scan_driver #(
        .N_DIGITS    (4),
        .PRESCALE    (4),
        .DEAD        (1),
        .BLINK_FRAMES(2),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic [15:0] d, input logic [3:0] dpb, input logic [3:0] blk,
                          input logic [3:0] bli, input logic lz,
                          input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                          input logic [6:0] s0, input logic [3:0] dpe);
        vec_t t;
        t.digits     = d;
        t.dp_bits    = dpb;
        t.blank_bits = blk;
        t.blink_bits = bli;
        t.lz         = lz;
        t.seg_exp    = {s3, s2, s1, s0};
        t.dp_exp     = dpe;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t v);
        digits_in = v.digits;
        dp_in     = v.dp_bits;
        blank_in  = v.blank_bits;
        blink_in  = v.blink_bits;
        lz_en     = v.lz;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Checks one 16-cycle frame; the next vector is driven mid-frame so shadowing is exercised.
    task automatic runFrame(input vec_t cur, input vec_t nxt, input int fnum, input bit first);
        for (int j = 0; j < 16; j++) begin
            int         s;
            int         c;
            logic [3:0] an_exp;
            logic [6:0] seg_e;
            logic       fs_exp;
            @(posedge clk);
            @(negedge clk);
            s      = j / 4;
            c      = j % 4;
            an_exp = (c == 0) ? 4'b1111 : ~(4'b0001 << s);
            seg_e  = cur.seg_exp[7*s +: 7];
            fs_exp = (j == 15) || (first && j == 0);
            checkOutput($sformatf("an f%0d c%0d", fnum, j), 32'(an), 32'(an_exp));
            checkOutput($sformatf("frame_start f%0d c%0d", fnum, j), 32'(frame_start), 32'(fs_exp));
            if (!first || j > 0) begin
                checkOutput($sformatf("seg f%0d c%0d", fnum, j), 32'(seg), 32'(seg_e));
                checkOutput($sformatf("dp f%0d c%0d", fnum, j), 32'(dp), 32'(cur.dp_exp[s]));
            end
            if (j == 7) applyStimulus(nxt);
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        // Frames 1-5: scan order, shadowing, blink (frames 2-3 dark), dp and blank.
        addVec(16'h1234, 4'b0000, 4'b0000, 4'b0001, 1'b0, glyphs[1], glyphs[2], glyphs[3], glyphs[4], 4'b1111);
        addVec(16'h5678, 4'b0000, 4'b0000, 4'b0001, 1'b0, glyphs[5], glyphs[6], glyphs[7], DARK, 4'b1111);
        addVec(16'h5678, 4'b0010, 4'b0000, 4'b0001, 1'b0, glyphs[5], glyphs[6], glyphs[7], DARK, 4'b1101);
        addVec(16'h5678, 4'b0010, 4'b0000, 4'b0001, 1'b0, glyphs[5], glyphs[6], glyphs[7], glyphs[8], 4'b1101);
        addVec(16'h9ABC, 4'b0100, 4'b0100, 4'b0001, 1'b0, glyphs[9], DARK, glyphs[11], glyphs[12], 4'b1111);
        // Leading-zero suppression cases.
        addVec(16'h0050, 4'b0000, 4'b0000, 4'b0000, 1'b1, DARK, DARK, glyphs[5], glyphs[0], 4'b1111);
        addVec(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, DARK, DARK, DARK, glyphs[0], 4'b1111);
        addVec(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, glyphs[0], glyphs[0], glyphs[0], glyphs[0], 4'b1111);
        addVec(16'h0050, 4'b0000, 4'b0000, 4'b0000, 1'b0, glyphs[0], glyphs[0], glyphs[5], glyphs[0], 4'b1111);
        addVec(16'hA00D, 4'b0000, 4'b0000, 4'b0000, 1'b1, glyphs[10], glyphs[0], glyphs[0], glyphs[13], 4'b1111);
        addVec(16'h00F0, 4'b1001, 4'b0000, 4'b0000, 1'b1, DARK, DARK, glyphs[15], glyphs[0], 4'b1110);
        // Glyph sweep on digit 0.
        for (int v = 0; v < 16; v++) begin
            logic [3:0] nib;
            nib = 4'(v);
            addVec({12'h000, nib}, 4'b0000, 4'b0000, 4'b0000, 1'b0,
                   glyphs[0], glyphs[0], glyphs[0], glyphs[v], 4'b1111);
        end
        n = vecs.size();

        // Reset state.
        rst_n = 1'b0;
        applyStimulus(vecs[0]);
        #12;
        checkOutput("reset an", 32'(an), 32'(4'b1111));
        checkOutput("reset seg", 32'(seg), 32'(DARK));
        checkOutput("reset dp", 32'(dp), 32'(1'b1));
        checkOutput("reset frame_start", 32'(frame_start), 32'(1'b0));

        @(negedge clk);
        rst_n = 1'b1;
        runFrame(vecs[0], vecs[0], 0, 1'b1);
        for (int i = 0; i < n; i++) begin
            runFrame(vecs[i], vecs[(i + 1 < n) ? i + 1 : i], i + 1, 1'b0);
        end

        // Asynchronous reset mid-slot: outputs go inactive before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async an", 32'(an), 32'(4'b1111));
        checkOutput("async seg", 32'(seg), 32'(DARK));
        checkOutput("async dp", 32'(dp), 32'(1'b1));
        checkOutput("async frame_start", 32'(frame_start), 32'(1'b0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("held an", 32'(an), 32'(4'b1111));
        checkOutput("held frame_start", 32'(frame_start), 32'(1'b0));

        // Release: first frame_start follows the first edge, digit 0 slot comes first.
        rst_n = 1'b1;
        runFrame(vecs[n-1], vecs[n-1], 99, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_scan_driver.md
# ss_scan_driver

Multiplexed N-digit seven-segment display driver. It time-slices one shared segment bus across `N_DIGITS` common-anode digits and decodes each 4-bit digit to the hex glyph set (0-9, A, b, C, d, E, F). On top of the single-digit decoder it adds per-digit decimal point, forced blanking, blinking and leading-zero suppression, and it latches its inputs once per frame so the display never tears. It sits between the clock/counter datapath and the board's segment/anode pins.

## Interface
- `N_DIGITS`, default 8: number of digits, 1..16.
- `PRESCALE`, default 1000: clocks per digit slot, ≥2.
- `DEAD`, default 2: anode-off cycles at the start of each slot (anti-ghosting), 0..PRESCALE-1.
- `BLINK_FRAMES`, default 64: full frames per blink half-period, ≥1.
- `ACTIVE_LOW`, default 1: 1 means `seg`, `dp` and `an` are active-low; 0 means all are active-high.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `digits_in` input, 4*N_DIGITS bits: digit i value on bits [4i+3:4i]; digit 0 is least significant and rightmost.
- `dp_in` input, N_DIGITS bits: decimal point request per digit.
- `blank_in` input, N_DIGITS bits: force digit dark.
- `blink_in` input, N_DIGITS bits: digit blinks.
- `lz_en` input, 1 bit: leading-zero suppression enable.
- `seg` output, 7 bits: segments, with seg[0]=a … seg[6]=g.
- `dp` output, 1 bit: decimal point segment.
- `an` output, N_DIGITS bits: digit enables, one-hot active.
- `frame_start` output, 1 bit: one-cycle pulse when a new frame's inputs are latched.

## Operation
- **Counters.**
  - `cnt` runs 0..PRESCALE-1.
  - `idx` runs 0..N_DIGITS-1.
  - On the edge where cnt==PRESCALE-1: cnt←0 and idx←idx+1, wrapping from N_DIGITS-1 to 0.
  - Counter widths are clog2 of their range, minimum 1 bit.
- **Shadow latch.**
  - `digits_in`, `dp_in`, `blank_in`, `blink_in` and `lz_en` are copied into shadow registers at the frame-wrap edge (cnt==PRESCALE-1 and idx==N_DIGITS-1).
  - They are also copied at the first edge after reset release.
  - Input changes at any other time have no effect until the next capture.
- **Glyphs.** Active-low patterns, listed g..a; invert all of them when ACTIVE_LOW=0.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Blanking.** A digit is dark when any of the following holds:
  - its `blank` bit is set;
  - its `blink` bit is set and the blink phase is OFF;
  - lz_en=1, its value is 0, all higher digits are 0, and it is not digit 0 (digit 0 is never suppressed);
  - only value 0 counts as zero; A-F are never suppressed.
- **Dark-digit outputs.** `seg` and `dp` are inactive, and `an` is still driven, so the duty cycle stays uniform.
- **Decimal point.** `dp` is active when the shadow dp bit for the current digit is set and the digit is not dark.
- **Blink phase.**
  - Reset value is ON.
  - It toggles after every BLINK_FRAMES frame-wrap edges.
- **Anode timing.** Within each slot, `an` is all-inactive for slot cycles cnt 0..DEAD-1 and one-hot on digit idx for cnt DEAD..PRESCALE-1.
- **Segment timing.** `seg`/`dp` carry digit idx for the whole slot.

## Timing
- **Registered outputs.** `seg`, `dp`, `an` and `frame_start` are registered, decoded from the pre-edge values of cnt, idx and the shadow registers. This gives exactly one clock of latency relative to the counters.
- **frame_start.**
  - Goes high for one cycle immediately after each shadow capture edge, including the first capture after reset.
  - Period is N_DIGITS*PRESCALE clocks.
- **Per-digit pattern per frame.** Each digit is active for PRESCALE-DEAD consecutive cycles, preceded by DEAD all-off cycles.
- **Reset values.** On asynchronous reset (including assertion mid-slot), the following take effect immediately:
  - cnt=0, idx=0, shadow registers = 0, blink phase ON, frame_start=0;
  - `an` all inactive, `seg` all inactive, `dp` inactive.
- **After reset release.** The first slot is digit 0, beginning with DEAD dark cycles.
- **Edge cases.**
  - N_DIGITS=1: idx stays 0, and every slot wrap is a frame wrap.
  - DEAD=0: no dark gap between digits.

## Test plan
- **Async reset.** Pull `rst_n` low mid-slot with ACTIVE_LOW=1 → `an` all ones, seg=1111111 and dp=1 in the same cycle without waiting for a clock edge, and frame_start=0. Release → the first frame_start pulse follows the first edge.
- **Scan order.** N_DIGITS=4, PRESCALE=4, DEAD=1, digits_in=0x1234, lz_en=0 → repeating 16-cycle frame:
  - one cycle an=1111, then 3 cycles an=1110 with seg=0011001 ("4");
  - then an=1111 for one cycle, then 3 cycles an=1101 with seg=0110000 ("3");
  - then "2" on an=1011, then "1" on an=0111;
  - frame_start pulses every 16 cycles.
- **Glyph sweep.** Step digit 0 through 0x0..0xF, one value per frame → each of the 16 patterns above appears, including F=0001110.
- **Leading zeros.** digits_in=0x0050, lz_en=1 → digits 3 and 2 show seg=1111111 while their anodes are active, digit 1 shows "5", digit 0 shows "0". digits_in=0x0000 → only digit 0 lit, showing "0". lz_en=0 → all four digits show their values.
- **Shadowing.** Change digits_in from 0x1234 to 0x5678 halfway through a frame → the remaining slots of that frame still show 1/2/3/4, and 5/6/7/8 appears from the slot after the next frame_start.
- **Blink, dp, blank.**
  - BLINK_FRAMES=2, blink_in=0001 → digit 0 lit in frames 0-1, dark in frames 2-3, lit again in frames 4-5.
  - dp_in=0010 → dp active only during digit 1's slot.
  - blank_in=0100 → digit 2 dark with dp inactive, even when dp_in bit 2 is set.
